cla_shift_add_multiplier: RTL and testbench

//  Sequential 32x32 -> 64-bit shift-add multiplier. One partial-product add per cycle, done by an instance of the
//  32-bit carry look-ahead adder (CLA32bit). Sits directly downstream of CLA32bit and consumes its sum/cout.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/cla_shift_add_multiplier_cla.sv | 37 +++
 rtl/cla_shift_add_multiplier.sv | 111 +++++++++++
 tb/tb_cla_shift_add_multiplier.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and state encoding for the shift-add multiplier
// Purpose: operand width, iteration counter width, FSM state encoding and the
//          two's-complement magnitude helper used by the multiplier top.
// Ports:   none (package).
package mul_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    MUL  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Magnitude of a 32-bit operand. With is_signed set, -2^31 maps to 2^31,
  // which is still representable as an unsigned 32-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    if (is_signed && x[WIDTH-1]) return ~x + 1'b1;
    return x;
  endfunction

endpackage

// File: rtl/cla_shift_add_multiplier_cla.sv
// rtl/cla_shift_add_multiplier_cla.sv - 32-bit carry look-ahead adder
// Purpose: combinational sum = a + b + cin built from eight 4-bit look-ahead
//          groups; the group carry-out feeds the next group's carry-in.
// Ports:   a, b (32) addends; cin carry in; sum (32); cout carry out.
module CLA32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/cla_shift_add_multiplier.sv
// rtl/cla_shift_add_multiplier.sv - sequential 32x32->64 shift-add multiplier
// Purpose: one partial-product add per cycle through a CLA32bit instance;
//          signed operands are reduced to magnitudes and the sign is restored
//          at the end. Latency from accept to out_valid is WIDTH+2 cycles.
// Ports:   clk, rst_n (async active-low);
//          in_valid/in_ready, a, b, in_signed  - operation input handshake;
//          out_valid/out_ready, product        - result handshake;
//          busy                                - high whenever not IDLE.
module cla_shift_add_multiplier
  import mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg;    // raw multiplicand, then its magnitude from PREP on
  logic [WIDTH-1:0] b_reg;
  logic             sgn;
  logic             neg;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;   // starts as |b|; shifted out as product bits shift in
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign add_b = acc_lo[0] ? a_reg : '0;

  CLA32bit u_cla (
    .a    (acc_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = PREP;
      end
      PREP: state_next = MUL;
      MUL:  if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn     <= 1'b0;
      neg     <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= b;
          sgn   <= in_signed;
        end
        PREP: begin
          a_reg  <= magnitude(a_reg, sgn);
          acc_lo <= magnitude(b_reg, sgn);
          acc_hi <= '0;
          neg    <= sgn & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          cnt    <= '0;
        end
        MUL: begin
          // The adder carry becomes the new top bit, so the accumulator never overflows.
          {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 1'b1;
        end
        FIX: product <= neg ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_shift_add_multiplier.sv
// tb/tb_cla_shift_add_multiplier.sv - scoreboard bench for cla_shift_add_multiplier
module tb_cla_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] product;
  logic        busy;

  cla_shift_add_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  logic [63:0] exp_q[$];
  int          acc_q[$];
  int          completed = 0;

  // Monitor: latency and in_ready checked on out_valid rise, hold checked each
  // stalled cycle, product popped and compared on the handshake cycle.
  bit          seen = 0;
  logic [63:0] held;
  int          rise;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        held = product;
        rise = cyc;
        check64("in_ready_in_done", {63'd0, in_ready}, 64'd0);
      end else begin
        check64("hold_product", product, held);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check64("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          int          t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check64("product", product, e);
          check64("latency", 64'(rise - t), 64'd34);
          completed++;
        end
        seen = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic [63:0] e, input bit track);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check64("timeout_in_ready", 64'd0, 64'd1);
    a = x;
    b = y;
    in_signed = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (track) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    check64("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check64("timeout_drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
    check64({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check64({tag, "_busy"},      {63'd0, busy},      64'd0);
    check64({tag, "_product"},   product,            64'd0);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [63:0] e;
  } vec_t;

  vec_t vecs[$] = '{
    '{32'd7,         32'd9,         1'b0, 64'd63},
    '{32'hFFFF_FFF6, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFCE},
    '{32'hFFFF_FFF6, 32'hFFFF_FFFB, 1'b1, 64'd50},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1},
    '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000},
    '{32'hFFFF_FFFF, 32'd1,         1'b1, 64'hFFFF_FFFF_FFFF_FFFF},
    '{32'h1234_5678, 32'd0,         1'b1, 64'd0},
    '{32'd0,         32'hFFFF_FFFF, 1'b0, 64'd0},
    '{32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000}
  };

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back directed vectors.
    foreach (vecs[i]) issue(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].e, 1'b1);
    drain();
    check64("busy_idle", {63'd0, busy}, 64'd0);

    // Backpressure plus in_valid pulses with other operands during MUL.
    out_ready = 1'b0;
    issue(32'd1000, 32'd3000, 1'b0, 64'd3000000, 1'b1);
    repeat (10) @(negedge clk);
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    in_signed = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) check64("timeout_out_valid", 64'd0, 64'd1);
    end
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Asynchronous reset in the middle of MUL discards the operation.
    issue(32'd5, 32'd6, 1'b0, 64'd30, 1'b0);
    repeat (16) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check64("no_output_after_reset", {63'd0, out_valid}, 64'd0);

    issue(32'd3, 32'd4, 1'b0, 64'd12, 1'b1);
    drain();

    check64("completed_count", 64'(completed), 64'd12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
